kbd_cmd_queue: RTL and testbench

Downstream stage of the PS/2 keyboard receiver. It captures each validated key-release code (`letra`/`new_data`), translates it into a 4-bit command code, and buffers the codes in a small FIFO. It returns the `new_data_pico` acknowledge pulse to the receiver. The FIFO is exposed to the PicoBlaze as two input ports, data and status.

---
 rtl/kbd_cmd_pkg.sv | 53 +++++
 rtl/kbd_cmd_fifo.sv | 82 ++++++++
 rtl/kbd_cmd_queue.sv | 105 ++++++++++
 tb/tb_kbd_cmd_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_cmd_pkg.sv
// Shared constants for the PS/2 command queue: scancodes, command codes,
// capture FSM encodings, default PicoBlaze port IDs and the scancode map.
package kbd_cmd_pkg;

  localparam int CMD_W = 4;

  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_T     = 8'h2C;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam logic [CMD_W-1:0] CMD_NONE  = 4'd0;
  localparam logic [CMD_W-1:0] CMD_F     = 4'd1;
  localparam logic [CMD_W-1:0] CMD_H     = 4'd2;
  localparam logic [CMD_W-1:0] CMD_T     = 4'd3;
  localparam logic [CMD_W-1:0] CMD_UP    = 4'd4;
  localparam logic [CMD_W-1:0] CMD_RIGHT = 4'd5;
  localparam logic [CMD_W-1:0] CMD_LEFT  = 4'd6;
  localparam logic [CMD_W-1:0] CMD_DOWN  = 4'd7;
  localparam logic [CMD_W-1:0] CMD_ESC   = 4'd8;
  localparam logic [CMD_W-1:0] CMD_ENTER = 4'd9;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACK      = 2'd1;
  localparam logic [1:0] ST_WAIT_CLR = 2'd2;

  localparam logic [7:0] DEFAULT_DATA_PORT   = 8'h0A;
  localparam logic [7:0] DEFAULT_STATUS_PORT = 8'h0B;

  // CMD_NONE marks a scancode that is acknowledged but never queued
  function automatic logic [CMD_W-1:0] map_scancode(input logic [7:0] sc);
    logic [CMD_W-1:0] cmd;
    case (sc)
      SC_F:     cmd = CMD_F;
      SC_H:     cmd = CMD_H;
      SC_T:     cmd = CMD_T;
      SC_UP:    cmd = CMD_UP;
      SC_RIGHT: cmd = CMD_RIGHT;
      SC_LEFT:  cmd = CMD_LEFT;
      SC_DOWN:  cmd = CMD_DOWN;
      SC_ESC:   cmd = CMD_ESC;
      SC_ENTER: cmd = CMD_ENTER;
      default:  cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/kbd_cmd_fifo.sv
// Small synchronous command FIFO with circular pointers, a count register and
// a flush input that empties the queue while still accepting a same-cycle push.
module kbd_cmd_fifo
  import kbd_cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [CMD_W-1:0]       push_data,
  output logic [CMD_W-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  // A full queue still takes a push when a pop frees the head slot this cycle
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (push) begin
        mem_d[0] = push_data;
        wr_ptr_d = PTR_W'(1);
        count_d  = CNT_W'(1);
      end
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/kbd_cmd_queue.sv
// Keyboard command queue: maps captured scancodes to commands, acknowledges the
// receiver and exposes the FIFO on two PicoBlaze ports. Option: KBD_CMD_ESC_FLUSH_EN.
module kbd_cmd_queue
  import kbd_cmd_pkg::*;
#(
  parameter int         DEPTH       = 8,
  parameter logic [7:0] DATA_PORT   = DEFAULT_DATA_PORT,
  parameter logic [7:0] STATUS_PORT = DEFAULT_STATUS_PORT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] letra,
  input  logic       new_data,
  output logic       new_data_pico,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] in_port
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]       state_q, state_d;
  logic             new_data_pico_q, new_data_pico_d;
  logic             ovf_q, ovf_d;
  logic [CMD_W-1:0] cmd;
  logic             capture, push, pop, flush;
  logic             ovf_set, ovf_clr;
  logic [CMD_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             full, empty;

  assign cmd     = map_scancode(letra);
  assign capture = (state_q == ST_IDLE) && new_data;
  assign push    = capture && (cmd != CMD_NONE);
  assign pop     = read_strobe && (port_id == DATA_PORT);
  assign ovf_clr = read_strobe && (port_id == STATUS_PORT);

`ifdef KBD_CMD_ESC_FLUSH_EN
  assign flush = capture && (cmd == CMD_ESC);
`else
  assign flush = 1'b0;
`endif

  // A flushing push always fits, and a pop frees room for a push when full
  assign ovf_set = push && !flush && full && !(pop && !empty);

  kbd_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (cmd),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d         = state_q;
    new_data_pico_d = capture;
    case (state_q)
      ST_IDLE:     if (new_data) state_d = ST_ACK;
      ST_ACK:      state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!new_data) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      new_data_pico_q <= 1'b0;
      ovf_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      new_data_pico_q <= new_data_pico_d;
      ovf_q           <= ovf_d;
    end
  end

  assign new_data_pico = new_data_pico_q;

  always_comb begin
    in_port = 8'h00;
    if (port_id == DATA_PORT) begin
      in_port = {4'h0, head};
    end else if (port_id == STATUS_PORT) begin
      in_port = {4'(count), 1'b0, ovf_q, full, ~empty};
    end
  end

endmodule

// File: tb/tb_kbd_cmd_queue.sv
// Directed bench for kbd_cmd_queue: table-driven scancode mapping plus
// hand-written handshake, overflow, full+pop, ESC and reset sequences.
module tb_kbd_cmd_queue;

  localparam int         DEPTH = 8;
  localparam logic [7:0] DPORT = 8'h0A;
  localparam logic [7:0] SPORT = 8'h0B;

  logic       clk;
  logic       reset;
  logic [7:0] letra;
  logic       new_data;
  logic       new_data_pico;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] in_port;

  int checks;
  int passes;

  typedef struct {
    logic [7:0] code;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] ovf_keys[9];
  logic [7:0] drain_exp[8];

  kbd_cmd_queue #(
    .DEPTH       (DEPTH),
    .DATA_PORT   (DPORT),
    .STATUS_PORT (SPORT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .letra         (letra),
    .new_data      (new_data),
    .new_data_pico (new_data_pico),
    .port_id       (port_id),
    .read_strobe   (read_strobe),
    .in_port       (in_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
    end else begin
      passes++;
    end
  endtask

  // Full receiver handshake for one key: ack must be a single-cycle pulse
  task automatic applyStimulus(input logic [7:0] code, input string name);
    letra    = code;
    new_data = 1'b1;
    @(negedge clk);
    checkOutput({name, " ack high"}, {7'b0, new_data_pico}, 8'h01);
    new_data = 1'b0;
    @(negedge clk);
    checkOutput({name, " ack low"}, {7'b0, new_data_pico}, 8'h00);
    @(negedge clk);
  endtask

  task automatic peekPort(input logic [7:0] port, input logic [7:0] expected,
                          input string name);
    port_id = port;
    #1;
    checkOutput(name, in_port, expected);
    port_id = 8'h00;
  endtask

  task automatic readPort(input logic [7:0] port, input logic [7:0] expected,
                          input string name);
    port_id     = port;
    read_strobe = 1'b1;
    #1;
    checkOutput(name, in_port, expected);
    @(negedge clk);
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h2B, 8'h01};
    vecs[1] = '{8'h33, 8'h02};
    vecs[2] = '{8'h2C, 8'h03};
    vecs[3] = '{8'h75, 8'h04};
    vecs[4] = '{8'h74, 8'h05};
    vecs[5] = '{8'h6B, 8'h06};
    vecs[6] = '{8'h72, 8'h07};
    vecs[7] = '{8'h5A, 8'h09};
    vecs[8] = '{8'h1C, 8'h00};
    vecs[9] = '{8'h00, 8'h00};
    ovf_keys  = '{8'h2B, 8'h33, 8'h2C, 8'h75, 8'h74, 8'h6B, 8'h72, 8'h5A, 8'h2B};
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'h02};

    checks      = 0;
    passes      = 0;
    reset       = 1'b1;
    letra       = 8'h00;
    new_data    = 1'b0;
    port_id     = 8'h00;
    read_strobe = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset ack", {7'b0, new_data_pico}, 8'h00);
    peekPort(SPORT, 8'h00, "reset status");
    peekPort(DPORT, 8'h00, "reset data");
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(8'h2B, "key 2B");
    readPort(SPORT, 8'h11, "one entry status");
    readPort(DPORT, 8'h01, "one entry data");
    readPort(SPORT, 8'h00, "drained status");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].code, $sformatf("map %02h", vecs[i].code));
      readPort(DPORT, vecs[i].exp_data, $sformatf("map %02h data", vecs[i].code));
      peekPort(SPORT, 8'h00, $sformatf("map %02h status", vecs[i].code));
    end

    applyStimulus(8'h75, "seq 75");
    applyStimulus(8'h74, "seq 74");
    applyStimulus(8'h5A, "seq 5A");
    peekPort(SPORT, 8'h31, "seq status");
    readPort(DPORT, 8'h04, "seq read 1");
    readPort(DPORT, 8'h05, "seq read 2");
    readPort(DPORT, 8'h09, "seq read 3");
    readPort(DPORT, 8'h00, "seq read empty");
    peekPort(SPORT, 8'h00, "seq empty status");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(ovf_keys[i], $sformatf("ovf key %0d", i));
    end
    readPort(SPORT, 8'h87, "overflow status");
    readPort(SPORT, 8'h83, "ovf cleared status");

    // New key captured on the same edge that pops the head of a full queue
    letra       = 8'h33;
    new_data    = 1'b1;
    port_id     = DPORT;
    read_strobe = 1'b1;
    #1;
    checkOutput("full pop head", in_port, 8'h01);
    @(negedge clk);
    read_strobe = 1'b0;
    port_id     = 8'h00;
    checkOutput("full pop ack", {7'b0, new_data_pico}, 8'h01);
    new_data = 1'b0;
    repeat (2) @(negedge clk);
    peekPort(SPORT, 8'h83, "full pop status");
    for (int i = 0; i < 8; i++) begin
      readPort(DPORT, drain_exp[i], $sformatf("drain %0d", i));
    end
    peekPort(SPORT, 8'h00, "drain status");

    applyStimulus(8'h2B, "pre 2B");
    applyStimulus(8'h1C, "unmapped 1C");
    peekPort(SPORT, 8'h11, "unmapped status");
    applyStimulus(8'h33, "pre 33");
    applyStimulus(8'h2C, "pre 2C");
    peekPort(SPORT, 8'h31, "pre esc status");
    applyStimulus(8'h76, "esc");
`ifdef KBD_CMD_ESC_FLUSH_EN
    readPort(SPORT, 8'h11, "esc flush status");
    readPort(DPORT, 8'h08, "esc flush data");
`else
    readPort(SPORT, 8'h41, "esc plain status");
    readPort(DPORT, 8'h01, "esc plain read 1");
    readPort(DPORT, 8'h02, "esc plain read 2");
    readPort(DPORT, 8'h03, "esc plain read 3");
    readPort(DPORT, 8'h08, "esc plain read 4");
`endif
    peekPort(SPORT, 8'h00, "esc final status");

    // Reset lands while the ack is high; the held key is taken again after
    letra    = 8'h75;
    new_data = 1'b1;
    @(negedge clk);
    checkOutput("pre-reset ack", {7'b0, new_data_pico}, 8'h01);
    reset = 1'b1;
    #1;
    checkOutput("reset kills ack", {7'b0, new_data_pico}, 8'h00);
    peekPort(SPORT, 8'h00, "reset clears count");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("recapture ack", {7'b0, new_data_pico}, 8'h01);
    new_data = 1'b0;
    peekPort(SPORT, 8'h11, "recapture status");
    @(negedge clk);
    checkOutput("recapture ack low", {7'b0, new_data_pico}, 8'h00);
    @(negedge clk);
    readPort(DPORT, 8'h04, "recapture data");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
